// File: rtl/sparc_exu_thr_pkg.sv
// Shared definitions for the EXU per-thread controllers: the thread
// count, the one-hot thread constants and a one-hot to binary encoder.
package sparc_exu_thr_pkg;

    localparam int NTHR = 4;

    localparam logic [NTHR-1:0] THR0 = 4'b0001;
    localparam logic [NTHR-1:0] THR1 = 4'b0010;
    localparam logic [NTHR-1:0] THR2 = 4'b0100;
    localparam logic [NTHR-1:0] THR3 = 4'b1000;

    // Encode a one-hot thread select into a 2-bit thread number.
    // The input must be one-hot; any other value gives an undefined result.
    function automatic logic [1:0] thr_enc(input logic [NTHR-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/sparc_exu_rr_pick.sv
// Combinational 4-way round-robin picker. The search starts at the
// thread just after the one-hot pointer and wraps upward mod 4, so the
// thread named by the pointer itself has the lowest priority.
module sparc_exu_rr_pick
    import sparc_exu_thr_pkg::*;
(
    input  logic [NTHR-1:0] elig,
    input  logic [NTHR-1:0] ptr,
    output logic [NTHR-1:0] gnt,
    output logic            any_gnt
);

    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    assign base = thr_enc(ptr);

    // Walk the four candidates in rotated order and grant the first eligible one.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NTHR; i++) begin
            idx = base + 2'(i);
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_gnt = found;

endmodule

// File: rtl/sparc_exu_thrsel.sv
// Four-thread issue scheduler and write sequencer for the EXU per-thread
// state registers. Picks one ready thread per cycle round-robin, carries
// its thread ID and write enable E -> M -> W, and resolves read-after-write
// hazards on the per-thread registers.
//
// Build option EXU_THRSEL_FWD_EN: when defined, the W-stage write data is
// forwarded into the E read (fwd_sel_e), so only a pending write in E
// blocks issue. When undefined, pending writes in both E and M interlock
// and fwd_sel_e is tied low.
//
// Issue semantics: issue_vld_e is a valid-only qualifier on thr_out. There
// is no ready back-pressure on it; stall freezes E and M in place, and a
// held valid E slot simply presents the same thread again next cycle.
module sparc_exu_thrsel
    import sparc_exu_thr_pkg::*;
#(
    parameter int NTHR = 4
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic [NTHR-1:0] thr_rdy,
    input  logic [NTHR-1:0] wr_req_s,
    input  logic            stall,
    input  logic            kill_m,
    output logic [NTHR-1:0] thr_out,
    output logic            issue_vld_e,
    output logic [NTHR-1:0] thr_w,
    output logic            wen_w,
    output logic            fwd_sel_e
);

    logic [NTHR-1:0] ptr;
    logic [NTHR-1:0] thr_e;
    logic            vld_e;
    logic            wen_e;
    logic [NTHR-1:0] thr_m;
    logic            vld_m;
    logic            wen_m;

    logic [NTHR-1:0] blk_e;
    logic [NTHR-1:0] blk_m;
    logic [NTHR-1:0] elig;
    logic [NTHR-1:0] gnt;
    logic            any_gnt;

    // A thread with a write still ahead of W must not read stale data.
    assign blk_e = (vld_e && wen_e) ? thr_e : '0;
`ifdef EXU_THRSEL_FWD_EN
    // The M-stage write reaches W exactly when a new pick reaches E, where
    // the forward path covers it.
    assign blk_m = '0;
`else
    assign blk_m = (vld_m && wen_m) ? thr_m : '0;
`endif

    assign elig = thr_rdy & ~blk_e & ~blk_m;

    sparc_exu_rr_pick u_pick (
        .elig    (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .any_gnt (any_gnt)
    );

    // E stage and round-robin pointer; thr_e holds on an empty slot so the
    // read select stays one-hot.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ptr   <= THR3;
            thr_e <= THR0;
            vld_e <= 1'b0;
            wen_e <= 1'b0;
        end else if (!stall) begin
            if (any_gnt) begin
                ptr   <= gnt;
                thr_e <= gnt;
                vld_e <= 1'b1;
                wen_e <= |(wr_req_s & gnt);
            end else begin
                vld_e <= 1'b0;
                wen_e <= 1'b0;
            end
        end
    end

    // M stage; a kill during a stall cancels the held write in place.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            thr_m <= THR0;
            vld_m <= 1'b0;
            wen_m <= 1'b0;
        end else if (stall) begin
            if (kill_m) begin
                wen_m <= 1'b0;
            end
        end else begin
            thr_m <= thr_e;
            vld_m <= vld_e;
            wen_m <= wen_e;
        end
    end

    // W stage; a stall inserts a bubble so the write in W fires only once.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            thr_w <= THR0;
            wen_w <= 1'b0;
        end else if (stall) begin
            wen_w <= 1'b0;
        end else begin
            thr_w <= thr_m;
            wen_w <= wen_m & vld_m & ~kill_m;
        end
    end

    assign thr_out     = thr_e;
    assign issue_vld_e = vld_e;

`ifdef EXU_THRSEL_FWD_EN
    assign fwd_sel_e = vld_e & wen_w & (thr_e == thr_w);
`else
    assign fwd_sel_e = 1'b0;
`endif

endmodule

// File: tb/tb_sparc_exu_thrsel.sv
// Directed testbench for sparc_exu_thrsel. Expected values are hand
// derived; the thread-2 interlock/forward vectors follow EXU_THRSEL_FWD_EN.
module tb_sparc_exu_thrsel;

    logic       clk;
    logic       arst_l;
    logic [3:0] thr_rdy;
    logic [3:0] wr_req_s;
    logic       stall;
    logic       kill_m;
    logic [3:0] thr_out;
    logic       issue_vld_e;
    logic [3:0] thr_w;
    logic       wen_w;
    logic       fwd_sel_e;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q[$];

    sparc_exu_thrsel dut (
        .clk         (clk),
        .arst_l      (arst_l),
        .thr_rdy     (thr_rdy),
        .wr_req_s    (wr_req_s),
        .stall       (stall),
        .kill_m      (kill_m),
        .thr_out     (thr_out),
        .issue_vld_e (issue_vld_e),
        .thr_w       (thr_w),
        .wen_w       (wen_w),
        .fwd_sel_e   (fwd_sel_e)
    );

    // Clock and initial reset level
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two cycles with the given inputs, then release.
    task automatic do_reset(input logic [3:0] rdy, input logic [3:0] wr);
        arst_l   = 1'b0;
        stall    = 1'b0;
        kill_m   = 1'b0;
        thr_rdy  = rdy;
        wr_req_s = wr;
        step();
        step();
        arst_l = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_thr_out"}, 32'(thr_out), 32'h1);
        check({tag, "_thr_w"}, 32'(thr_w), 32'h1);
        check({tag, "_vld"}, 32'(issue_vld_e), 32'h0);
        check({tag, "_wen_w"}, 32'(wen_w), 32'h0);
        check({tag, "_fwd"}, 32'(fwd_sel_e), 32'h0);
    endtask

    initial begin
        logic [3:0] exp_thr;
        logic       v_vld[6];
        logic       v_wen[6];
        logic       v_fwd[6];
        logic       stall_vld;

        arst_l   = 1'b0;
        thr_rdy  = 4'b1111;
        wr_req_s = 4'b0000;
        stall    = 1'b0;
        kill_m   = 1'b0;

        // Test 1: reset values, then round-robin over four ready threads
        do_reset(4'b1111, 4'b0000);
        arst_l = 1'b0;
        #1;
        check_reset_outputs("rst");
        arst_l = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        while (exp_q.size() > 0) begin
            step();
            exp_thr = exp_q.pop_front();
            check("rr_thr_out", 32'(thr_out), 32'(exp_thr));
            check("rr_vld", 32'(issue_vld_e), 32'h1);
            check("rr_wen_w", 32'(wen_w), 32'h0);
        end

        // Test 2: only thread 2 ready, always writing
`ifdef EXU_THRSEL_FWD_EN
        v_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v_wen = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v_fwd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        v_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        v_wen = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        v_fwd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset(4'b0100, 4'b0100);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t2_vld_%0d", i), 32'(issue_vld_e), 32'(v_vld[i]));
            check($sformatf("t2_wen_w_%0d", i), 32'(wen_w), 32'(v_wen[i]));
            check($sformatf("t2_fwd_%0d", i), 32'(fwd_sel_e), 32'(v_fwd[i]));
            check($sformatf("t2_thr_out_%0d", i), 32'(thr_out), 32'h4);
            if (v_wen[i]) begin
                check($sformatf("t2_thr_w_%0d", i), 32'(thr_w), 32'h4);
            end
        end

        // Test 3: threads 0 and 1 writing, thread 0 killed in M
        do_reset(4'b0011, 4'b0011);
        step();
        check("kill_e0", 32'(thr_out), 32'h1);
        step();
        check("kill_e1", 32'(thr_out), 32'h2);
        kill_m = 1'b1;
        step();
        kill_m = 1'b0;
        check("kill_wen_w_t0", 32'(wen_w), 32'h0);
        step();
        check("kill_wen_w_t1", 32'(wen_w), 32'h1);
        check("kill_thr_w_t1", 32'(thr_w), 32'h2);

        // Test 4: three-cycle stall while thread 3's write sits in W
`ifdef EXU_THRSEL_FWD_EN
        stall_vld = 1'b1;
`else
        stall_vld = 1'b0;
`endif
        do_reset(4'b1000, 4'b1000);
        step();
        step();
        step();
        stall = 1'b1;
        check("stl_wen_w_first", 32'(wen_w), 32'h1);
        check("stl_thr_w_first", 32'(thr_w), 32'h8);
        check("stl_thr_out_first", 32'(thr_out), 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stl_wen_w_%0d", i), 32'(wen_w), 32'h0);
            check($sformatf("stl_thr_w_%0d", i), 32'(thr_w), 32'h8);
            check($sformatf("stl_thr_out_%0d", i), 32'(thr_out), 32'h8);
            check($sformatf("stl_vld_%0d", i), 32'(issue_vld_e), 32'(stall_vld));
        end
        stall = 1'b0;
        step();
        check("stl_no_dup", 32'(wen_w), 32'h0);

        // Test 5: asynchronous reset with writes in flight in E and M
        do_reset(4'b1111, 4'b1111);
        step();
        check("ar_e0", 32'(thr_out), 32'h1);
        step();
        check("ar_e1", 32'(thr_out), 32'h2);
        arst_l = 1'b0;
        #1;
        check_reset_outputs("ar");
        step();
        thr_rdy = 4'b0000;
        step();
        arst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ar_wen_w_%0d", i), 32'(wen_w), 32'h0);
            check($sformatf("ar_idle_vld_%0d", i), 32'(issue_vld_e), 32'h0);
        end
        thr_rdy  = 4'b0001;
        wr_req_s = 4'b0001;
        step();
        check("ar_new_vld", 32'(issue_vld_e), 32'h1);
        check("ar_new_wen0", 32'(wen_w), 32'h0);
        thr_rdy = 4'b0000;
        step();
        check("ar_new_wen1", 32'(wen_w), 32'h0);
        step();
        check("ar_new_wen_w", 32'(wen_w), 32'h1);
        check("ar_new_thr_w", 32'(thr_w), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
